// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bus between the control path and the
// multi-cycle data memory responder.
interface data_mem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Busy;
    logic        AddrError;

    modport master (
        output MemRead, MemWrite, Address, WriteData,
        input  ReadData, Ready, Busy, AddrError
    );

    modport slave (
        input  MemRead, MemWrite, Address, WriteData,
        output ReadData, Ready, Busy, AddrError
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle word-addressed data memory with wait states, a one-cycle
// Ready pulse per request and rejection of misaligned, out-of-range or
// conflicting (read+write) requests.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset,
    data_mem_responder_if.slave bus
);
    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] HI_MASK   = ~((32'd1 << (IDX_W + 2)) - 32'd1);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic        HAS_WAIT  = (WAIT_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;
    logic        accept_s;

    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        rd_r;
    logic        wr_r;

    logic [31:0] eff_addr_s;
    logic [31:0] eff_wdata_s;
    logic        eff_rd_s;
    logic        eff_wr_s;
    logic        err_s;
    logic        enter_resp_s;
    logic        wr_ok_s;
    logic        rd_ok_s;
    logic [IDX_W-1:0] idx_s;

    logic [31:0] mem_r [DEPTH_WORDS];
    logic [31:0] rdata_r;
    logic        ready_r;
    logic        busy_r;
    logic        err_r;

    // A request is rejected when not word aligned, beyond the storage, or
    // asking for read and write at the same time.
    function automatic logic addr_error(input logic [31:0] addr,
                                        input logic        rd,
                                        input logic        wr);
        return (addr[1:0] != 2'b00) || ((addr & HI_MASK) != 32'd0) || (rd && wr);
    endfunction

    // Next-state and wait-counter logic; inputs only matter in IDLE.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.MemRead || bus.MemWrite) begin
                    accept_s = 1'b1;
                    if (HAS_WAIT) begin
                        state_s = WAIT;
                        cnt_s   = WAIT_LOAD;
                    end else begin
                        state_s = RESP;
                        cnt_s   = 4'd0;
                    end
                end else begin
                    state_s = IDLE;
                    cnt_s   = 4'd0;
                end
            end
            WAIT: begin
                // Counter is loaded on accept and exits once it reaches zero.
                if (cnt_r == 4'd0) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Effective request: live inputs on the accepting edge, captured copy after.
    always_comb begin
        eff_addr_s  = addr_r;
        eff_wdata_s = wdata_r;
        eff_rd_s    = rd_r;
        eff_wr_s    = wr_r;
        if (state_r == IDLE) begin
            eff_addr_s  = bus.Address;
            eff_wdata_s = bus.WriteData;
            eff_rd_s    = bus.MemRead;
            eff_wr_s    = bus.MemWrite;
        end else begin
            eff_addr_s  = addr_r;
            eff_wdata_s = wdata_r;
            eff_rd_s    = rd_r;
            eff_wr_s    = wr_r;
        end
    end

    assign err_s        = addr_error(eff_addr_s, eff_rd_s, eff_wr_s);
    assign enter_resp_s = (state_s == RESP);
    assign wr_ok_s      = enter_resp_s && eff_wr_s && !err_s;
    assign rd_ok_s      = enter_resp_s && eff_rd_s && !err_s;
    assign idx_s        = eff_addr_s[IDX_W+1:2];

    // FSM state, wait counter and request capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                addr_r  <= bus.Address;
                wdata_r <= bus.WriteData;
                rd_r    <= bus.MemRead;
                wr_r    <= bus.MemWrite;
            end
        end
    end

    // Registered status outputs derived from the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ready_r <= enter_resp_s;
            busy_r  <= (state_s != IDLE);
            err_r   <= enter_resp_s && err_s;
        end
    end

    // Storage array: committed only by a valid write entering RESP.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (wr_ok_s) begin
            mem_r[idx_s] <= eff_wdata_s;
        end
    end

    // Load data register: holds until the next valid read completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_r <= 32'd0;
        end else if (rd_ok_s) begin
            rdata_r <= mem_r[idx_s];
        end
    end

    assign bus.ReadData  = rdata_r;
    assign bus.Ready     = ready_r;
    assign bus.Busy      = busy_r;
    assign bus.AddrError = err_r;
endmodule
